// File: rtl/run_ctrl_if.sv
// Board-side bundle for run_ctrl: switch/button/breakpoint inputs and
// the CPU clock-enable plus debug-bus status outputs.
interface run_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic             step;
    logic             bp_en;
    logic [31:0]      bp_addr;
    logic [31:0]      pc;
    logic             cpu_en;
    logic [1:0]       state;
    logic             halted;
    logic [CNT_W-1:0] cyc_cnt;

    modport master (
        output run, step, bp_en, bp_addr, pc,
        input  cpu_en, state, halted, cyc_cnt
    );

    modport slave (
        input  run, step, bp_en, bp_addr, pc,
        output cpu_en, state, halted, cyc_cnt
    );
endinterface

// File: rtl/run_ctrl.sv
// Run/step/breakpoint controller: generates the CPU-wide clock enable and
// reports controller state and the enabled-cycle count.
module run_ctrl #(
    parameter int STEP_CYCLES = 1,
    parameter int CNT_W       = 32
) (
    input  logic        clk,
    input  logic        rst,
    run_ctrl_if.slave   dbg
);
    localparam int SC_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [SC_W-1:0] STEP_LOAD = SC_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        PAUSE = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        BREAK = 2'd3
    } state_t;

    state_t           state_r;
    logic             halted_r;
    logic [SC_W-1:0]  step_cnt_r;
    logic [CNT_W-1:0] cyc_cnt_r;
    logic             run_meta_r;
    logic             run_sync_r;
    logic             step_s0_r;
    logic             step_s1_r;
    logic             step_s2_r;
    logic             bp_hit_s;
    logic             step_rise_s;
    logic             cpu_en_s;

    function automatic logic pc_match(input logic en, input logic [31:0] pc,
                                      input logic [31:0] addr);
        return en & (pc == addr);
    endfunction

    assign bp_hit_s    = pc_match(dbg.bp_en, dbg.pc, dbg.bp_addr);
    assign step_rise_s = step_s1_r & ~step_s2_r;

    // Clock enable: RUN freezes in the same cycle the IF-stage PC hits the breakpoint
    always_comb begin
        cpu_en_s = 1'b0;
        case (state_r)
            RUN:     cpu_en_s = ~bp_hit_s;
            STEP:    cpu_en_s = 1'b1;
            PAUSE:   cpu_en_s = 1'b0;
            BREAK:   cpu_en_s = 1'b0;
            default: cpu_en_s = 1'b0;
        endcase
    end

    // Synchronizers for the asynchronous run switch and step button
    always_ff @(posedge clk) begin
        if (rst) begin
            run_meta_r <= 1'b0;
            run_sync_r <= 1'b0;
            step_s0_r  <= 1'b0;
            step_s1_r  <= 1'b0;
            step_s2_r  <= 1'b0;
        end else begin
            run_meta_r <= dbg.run;
            run_sync_r <= run_meta_r;
            step_s0_r  <= dbg.step;
            step_s1_r  <= step_s0_r;
            step_s2_r  <= step_s1_r;
        end
    end

    // Controller FSM with registered halted flag and step down-counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= PAUSE;
            halted_r   <= 1'b0;
            step_cnt_r <= {SC_W{1'b0}};
        end else begin
            case (state_r)
                PAUSE: begin
                    halted_r <= 1'b0;
                    if (run_sync_r) begin
                        state_r <= RUN;
                    end else if (step_rise_s) begin
                        state_r    <= STEP;
                        step_cnt_r <= STEP_LOAD;
                    end else begin
                        state_r <= PAUSE;
                    end
                end
                RUN: begin
                    if (bp_hit_s) begin
                        state_r  <= BREAK;
                        halted_r <= 1'b1;
                    end else if (!run_sync_r) begin
                        state_r  <= PAUSE;
                        halted_r <= 1'b0;
                    end else begin
                        state_r  <= RUN;
                        halted_r <= 1'b0;
                    end
                end
                STEP: begin
                    halted_r <= 1'b0;
                    if (step_cnt_r == {SC_W{1'b0}}) begin
                        state_r <= PAUSE;
                    end else begin
                        state_r    <= STEP;
                        step_cnt_r <= step_cnt_r - SC_W'(1'b1);
                    end
                end
                BREAK: begin
                    // Only a run release or a step press leaves BREAK
                    if (!run_sync_r) begin
                        state_r  <= PAUSE;
                        halted_r <= 1'b0;
                    end else if (step_rise_s) begin
                        state_r    <= STEP;
                        step_cnt_r <= STEP_LOAD;
                        halted_r   <= 1'b0;
                    end else begin
                        state_r  <= BREAK;
                        halted_r <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= PAUSE;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    // Enabled-cycle counter, wraps freely
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt_r <= {CNT_W{1'b0}};
        end else if (cpu_en_s) begin
            cyc_cnt_r <= cyc_cnt_r + CNT_W'(1'b1);
        end else begin
            cyc_cnt_r <= cyc_cnt_r;
        end
    end

    assign dbg.cpu_en  = cpu_en_s;
    assign dbg.state   = state_r;
    assign dbg.halted  = halted_r;
    assign dbg.cyc_cnt = cyc_cnt_r;
endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: three instances (1/4/8 step cycles, one with a 4-bit
// counter) share stimulus and are checked against a mode-level model.
module tb_run_ctrl;
    localparam int STEPS [3] = '{1, 4, 8};
    localparam int CWS   [3] = '{32, 4, 32};

    typedef struct {
        logic        rst;
        logic        run;
        logic        step;
        logic [1:0]  st;
        logic        en;
        logic [31:0] cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        step;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc_m [3];

    logic        dut_en   [3];
    logic [1:0]  dut_st   [3];
    logic        dut_halt [3];
    logic [31:0] dut_cnt  [3];

    int          nvec = 0;
    int          nerr = 0;
    bit          model_valid = 1'b0;

    // Model state: mode 0..3, cycles still owed in a step, counter, sync histories
    int          m_mode [3];
    int          m_left [3];
    logic [63:0] m_cnt  [3];
    logic [1:0]  m_runh [3];
    logic [2:0]  m_steph[3];

    vec_t        vecs[$];

    always #5 clk = ~clk;

    run_ctrl_if #(.CNT_W(32)) bus0 ();
    run_ctrl_if #(.CNT_W(4))  bus1 ();
    run_ctrl_if #(.CNT_W(32)) bus2 ();

    assign bus0.run = run;   assign bus1.run = run;   assign bus2.run = run;
    assign bus0.step = step; assign bus1.step = step; assign bus2.step = step;
    assign bus0.bp_en = bp_en; assign bus1.bp_en = bp_en; assign bus2.bp_en = bp_en;
    assign bus0.bp_addr = bp_addr; assign bus1.bp_addr = bp_addr; assign bus2.bp_addr = bp_addr;
    assign bus0.pc = pc_m[0]; assign bus1.pc = pc_m[1]; assign bus2.pc = pc_m[2];

    assign dut_en[0] = bus0.cpu_en;  assign dut_en[1] = bus1.cpu_en;  assign dut_en[2] = bus2.cpu_en;
    assign dut_st[0] = bus0.state;   assign dut_st[1] = bus1.state;   assign dut_st[2] = bus2.state;
    assign dut_halt[0] = bus0.halted; assign dut_halt[1] = bus1.halted; assign dut_halt[2] = bus2.halted;
    assign dut_cnt[0] = bus0.cyc_cnt;
    assign dut_cnt[1] = {28'd0, bus1.cyc_cnt};
    assign dut_cnt[2] = bus2.cyc_cnt;

    run_ctrl #(.STEP_CYCLES(1), .CNT_W(32)) u_dut0 (.clk(clk), .rst(rst), .dbg(bus0));
    run_ctrl #(.STEP_CYCLES(4), .CNT_W(4))  u_dut1 (.clk(clk), .rst(rst), .dbg(bus1));
    run_ctrl #(.STEP_CYCLES(8), .CNT_W(32)) u_dut2 (.clk(clk), .rst(rst), .dbg(bus2));

    task automatic chk(input string name, input int i, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", name, i, act, exp, $time);
        end
    endtask

    function automatic bit m_hit(input int i);
        return bp_en && (pc_m[i] == bp_addr);
    endfunction

    function automatic bit m_en(input int i);
        if (m_mode[i] == 1) return !m_hit(i);
        if (m_mode[i] == 2) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_update(input int i, input bit en);
        bit run_s, rise, hit;
        if (rst) begin
            m_mode[i] = 0; m_left[i] = 0; m_cnt[i] = 64'd0;
            m_runh[i] = 2'b00; m_steph[i] = 3'b000;
            return;
        end
        run_s = m_runh[i][1];
        rise  = m_steph[i][1] && !m_steph[i][2];
        hit   = m_hit(i);
        m_cnt[i] = (m_cnt[i] + {63'd0, en}) & ((64'd1 << CWS[i]) - 64'd1);
        case (m_mode[i])
            0: if (run_s) m_mode[i] = 1;
               else if (rise) begin m_mode[i] = 2; m_left[i] = STEPS[i]; end
            1: if (hit) m_mode[i] = 3;
               else if (!run_s) m_mode[i] = 0;
            2: begin
                m_left[i] = m_left[i] - 1;
                if (m_left[i] == 0) m_mode[i] = 0;
            end
            default: if (!run_s) m_mode[i] = 0;
               else if (rise) begin m_mode[i] = 2; m_left[i] = STEPS[i]; end
        endcase
        m_runh[i]  = {m_runh[i][0], run};
        m_steph[i] = {m_steph[i][1:0], step};
    endtask

    // One clock: check cpu_en before the edge, advance model, check registers after
    task automatic tick();
        bit en_x [3];
        #1;
        for (int i = 0; i < 3; i++) begin
            en_x[i] = m_en(i);
            if (model_valid) chk("cpu_en", i, {63'd0, dut_en[i]}, {63'd0, en_x[i]});
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_update(i, en_x[i]);
        if (rst) model_valid = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (model_valid) begin
                chk("state", i, {62'd0, dut_st[i]}, m_mode[i]);
                chk("halted", i, {63'd0, dut_halt[i]}, {63'd0, m_mode[i] == 3});
                chk("cyc_cnt", i, {32'd0, dut_cnt[i]}, m_cnt[i]);
            end
            if (en_x[i]) pc_m[i] = pc_m[i] + 32'd4;
        end
    endtask

    task automatic reset_all();
        rst = 1'b1; run = 1'b0; step = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic add_vec(input logic r, input logic ru, input logic s, input logic [1:0] st,
                           input logic en, input logic [31:0] cnt, input int n);
        vec_t v;
        v.rst = r; v.run = ru; v.step = s; v.st = st; v.en = en; v.cnt = cnt;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; step = 1'b0; bp_en = 1'b0; bp_addr = 32'd0;
        for (int i = 0; i < 3; i++) pc_m[i] = 32'h0000_1000;

        // Expected values for the STEP_CYCLES=1 instance, sampled after each edge
        add_vec(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 2);
        add_vec(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 11);
        add_vec(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'd0, 2);
        add_vec(1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 32'd0, 1);
        add_vec(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'd1, 17);
        add_vec(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd1, 3);
        add_vec(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'd1, 2);
        add_vec(1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 32'd1, 1);
        add_vec(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'd2, 1);
        add_vec(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd2, 2);

        foreach (vecs[k]) begin
            rst = vecs[k].rst; run = vecs[k].run; step = vecs[k].step;
            tick();
            chk("tbl_state", 0, {62'd0, dut_st[0]}, {62'd0, vecs[k].st});
            chk("tbl_cpu_en", 0, {63'd0, dut_en[0]}, {63'd0, vecs[k].en});
            chk("tbl_cyc_cnt", 0, {32'd0, dut_cnt[0]}, {32'd0, vecs[k].cnt});
        end

        // Multi-step: second press lands while stepping and is lost
        reset_all();
        step = 1'b1; tick(); tick();
        step = 1'b0; tick();
        step = 1'b1; repeat (8) tick();
        step = 1'b0; repeat (3) tick();
        chk("multi_cnt", 1, {32'd0, dut_cnt[1]}, 64'd4);
        chk("multi_state", 1, {62'd0, dut_st[1]}, 64'd0);

        // Breakpoint at 0x3010 running from 0x3000
        reset_all();
        for (int i = 0; i < 3; i++) pc_m[i] = 32'h0000_3000;
        bp_en = 1'b1; bp_addr = 32'h0000_3010; run = 1'b1;
        for (int k = 0; k < 30 && !dut_halt[0]; k++) tick();
        chk("bp_halted", 0, {63'd0, dut_halt[0]}, 64'd1);
        chk("bp_state", 0, {62'd0, dut_st[0]}, 64'd3);
        chk("bp_cnt", 0, {32'd0, dut_cnt[0]}, 64'd4);
        chk("bp_cpu_en", 0, {63'd0, dut_en[0]}, 64'd0);
        run = 1'b0; repeat (3) tick();
        chk("bp_pause", 0, {62'd0, dut_st[0]}, 64'd0);
        step = 1'b1; repeat (5) tick();
        step = 1'b0; tick();
        chk("bp_step_cnt", 0, {32'd0, dut_cnt[0]}, 64'd5);
        chk("bp_step_state", 0, {62'd0, dut_st[0]}, 64'd0);
        run = 1'b1; repeat (6) tick();
        run = 1'b0; repeat (3) tick();

        // Entering RUN with pc already on the breakpoint: zero enabled cycles
        reset_all();
        for (int i = 0; i < 3; i++) pc_m[i] = 32'h0000_3010;
        run = 1'b1; repeat (4) tick();
        chk("bp0_state", 0, {62'd0, dut_st[0]}, 64'd3);
        chk("bp0_cnt", 0, {32'd0, dut_cnt[0]}, 64'd0);
        step = 1'b1; repeat (4) tick();
        chk("bp0_step_cnt", 0, {32'd0, dut_cnt[0]}, 64'd1);
        step = 1'b0; run = 1'b0; repeat (4) tick();

        // Reset during an 8-cycle step after 3 enabled cycles
        reset_all();
        bp_en = 1'b0;
        step = 1'b1; tick(); tick();
        step = 1'b0; repeat (4) tick();
        chk("rst_pre_cnt", 2, {32'd0, dut_cnt[2]}, 64'd3);
        rst = 1'b1; tick();
        chk("rst_state", 2, {62'd0, dut_st[2]}, 64'd0);
        chk("rst_cpu_en", 2, {63'd0, dut_en[2]}, 64'd0);
        chk("rst_cnt", 2, {32'd0, dut_cnt[2]}, 64'd0);
        rst = 1'b0; repeat (12) tick();
        chk("rst_idle_cnt", 2, {32'd0, dut_cnt[2]}, 64'd0);

        // 17 enabled cycles wrap a 4-bit counter to 1
        reset_all();
        run = 1'b1; repeat (3) tick();
        repeat (17) tick();
        chk("wrap_cnt4", 1, {32'd0, dut_cnt[1]}, 64'd1);
        chk("wrap_cnt32", 0, {32'd0, dut_cnt[0]}, 64'd17);
        run = 1'b0; repeat (4) tick();

        // Random soak against the model
        reset_all();
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 19) == 0) run = ~run;
            if ($urandom_range(0, 5) == 0) step = ~step;
            if ($urandom_range(0, 29) == 0) bp_en = ~bp_en;
            if ($urandom_range(0, 9) == 0)
                bp_addr = pc_m[$urandom_range(0, 2)] + 32'd4 * $urandom_range(0, 6);
            if ($urandom_range(0, 149) == 0)
                for (int i = 0; i < 3; i++) pc_m[i] = {$urandom_range(0, 65535), 2'b00};
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
